ifmap_decompressor: RTL and testbench

IFMAP_DECOMPRESSOR -- requirements
Module: ifmap_decompressor

---
 rtl/ifmap_decompressor.sv | 219 +++++++++++++++++++++
 tb/tb_ifmap_decompressor.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_decompressor.sv
// ifmap_decompressor: expands run-length compressed ifmap tokens into 8-byte
// packets and queues them in a small FIFO for the global ifmap buffer.
// Token: [15] run flag, [14] last flag, [7:0] literal byte or run length.
// Packet bus layout: {packet_valid, valid_mask[7:0], data[63:0]} with
// byte i of the packet at data[8*i+7:8*i].
module ifmap_decompressor #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PACKET_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             comp_data_in,
  input  logic                    comp_valid_in,
  output logic                    comp_ready_out,
  input  logic                    global_buffer_req,
  output logic                    decompressor_ack,
  output logic [PACKET_BYTES*9:0] decompressed_fifo_packet,
  output logic                    frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(PACKET_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RUN    = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t                         r_state;
  logic [PACKET_BYTES-1:0][7:0]   r_staging;
  logic [3:0]                     r_stage_cnt;
  logic [7:0]                     r_run_rem;
  logic                           r_last_latched;
  logic                           r_frame_done;

  logic [PACKET_BYTES*8-1:0]      r_mem_data [FIFO_DEPTH];
  logic [PACKET_BYTES-1:0]        r_mem_mask [FIFO_DEPTH];
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [CNT_W-1:0]               r_count;

  logic                           w_not_empty;
  logic                           w_fifo_full;
  logic                           w_pop;
  logic                           w_space;
  logic                           w_stage_full;
  logic                           w_accept;
  logic                           w_push;
  logic                           w_run_done;
  logic [3:0]                     w_room;
  logic [3:0]                     w_run_n;
  logic [3:0]                     w_stage_end;
  logic [PACKET_BYTES-1:0]        w_zero_mask;
  logic [PACKET_BYTES-1:0]        w_push_mask;
  logic [PACKET_BYTES*8-1:0]      w_push_data;
  logic                           w_unused;

  // Token bits [13:8] carry no meaning for this block.
  assign w_unused = ^comp_data_in[13:8];

  assign w_not_empty  = (r_count != {CNT_W{1'b0}});
  assign w_fifo_full  = (r_count == DEPTH_CNT);
  assign w_pop        = global_buffer_req & w_not_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for a push.
  assign w_space      = ~w_fifo_full | w_pop;
  assign w_stage_full = (r_stage_cnt == FULL_CNT);

  // A token seen together with start or rst is never taken.
  assign comp_ready_out   = (r_state == ACTIVE) & (r_stage_cnt < FULL_CNT) & ~start & ~rst;
  assign w_accept         = comp_valid_in & comp_ready_out;
  assign decompressor_ack = w_pop;
  assign frame_done       = r_frame_done;

  // Full packets drain in any state; a partial packet only closes a frame.
  assign w_push = ~start & w_space &
                  (w_stage_full | ((r_state == FLUSH) & (r_stage_cnt != 4'd0)));

  // Zero bytes a run may write this cycle: min(run_rem, free staging bytes).
  assign w_room      = FULL_CNT - r_stage_cnt;
  assign w_run_n     = (r_run_rem < {4'd0, w_room}) ? r_run_rem[3:0] : w_room;
  assign w_stage_end = r_stage_cnt + w_run_n;
  assign w_run_done  = (r_run_rem == {4'd0, w_run_n});

  // Build the packet to push (unfilled bytes zeroed) and the run zero-fill range.
  always_comb begin
    w_push_data = {(PACKET_BYTES*8){1'b0}};
    w_push_mask = {PACKET_BYTES{1'b0}};
    w_zero_mask = {PACKET_BYTES{1'b0}};
    for (int i = 0; i < PACKET_BYTES; i++) begin
      if (4'(i) < r_stage_cnt) begin
        w_push_data[8*i +: 8] = r_staging[i];
        w_push_mask[i]        = 1'b1;
      end else begin
        w_push_data[8*i +: 8] = 8'd0;
        w_push_mask[i]        = 1'b0;
      end
      if ((4'(i) >= r_stage_cnt) && (4'(i) < w_stage_end)) begin
        w_zero_mask[i] = 1'b1;
      end else begin
        w_zero_mask[i] = 1'b0;
      end
    end
  end

  // Present the FIFO head; an empty FIFO shows an all-zero packet.
  always_comb begin
    if (w_not_empty) begin
      decompressed_fifo_packet = {1'b1, r_mem_mask[r_rd_ptr], r_mem_data[r_rd_ptr]};
    end else begin
      decompressed_fifo_packet = {(PACKET_BYTES*9+1){1'b0}};
    end
  end

  // Frame FSM: token intake, run expansion, staging drain and frame close.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_staging      <= {(PACKET_BYTES*8){1'b0}};
      r_stage_cnt    <= 4'd0;
      r_run_rem      <= 8'd0;
      r_last_latched <= 1'b0;
      r_frame_done   <= 1'b0;
    end else if (start) begin
      r_state        <= ACTIVE;
      r_staging      <= {(PACKET_BYTES*8){1'b0}};
      r_stage_cnt    <= 4'd0;
      r_run_rem      <= 8'd0;
      r_last_latched <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_stage_full) begin
        // Drain cycle: no staging write; stalls here while the FIFO is full.
        if (w_space) begin
          r_stage_cnt <= 4'd0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          ACTIVE: begin
            if (w_accept) begin
              if (comp_data_in[14]) begin
                r_last_latched <= 1'b1;
              end
              if (!comp_data_in[15]) begin
                r_staging[r_stage_cnt[2:0]] <= comp_data_in[7:0];
                r_stage_cnt <= r_stage_cnt + 4'd1;
                if (comp_data_in[14]) begin
                  r_state <= FLUSH;
                end
              end else if (comp_data_in[7:0] != 8'd0) begin
                r_run_rem <= comp_data_in[7:0];
                r_state   <= RUN;
              end else if (comp_data_in[14]) begin
                r_state <= FLUSH;
              end
            end
          end
          RUN: begin
            for (int i = 0; i < PACKET_BYTES; i++) begin
              if (w_zero_mask[i]) begin
                r_staging[i] <= 8'd0;
              end
            end
            r_stage_cnt <= w_stage_end;
            r_run_rem   <= r_run_rem - {4'd0, w_run_n};
            if (w_run_done) begin
              r_state <= r_last_latched ? FLUSH : ACTIVE;
            end
          end
          FLUSH: begin
            if (r_stage_cnt == 4'd0) begin
              r_state      <= IDLE;
              r_frame_done <= 1'b1;
            end else if (w_space) begin
              r_stage_cnt  <= 4'd0;
              r_state      <= IDLE;
              r_frame_done <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Packet FIFO pointers and occupancy; start empties it like reset.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_mem_mask[r_wr_ptr] <= w_push_mask;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_decompressor.sv
// Directed bench for ifmap_decompressor: a token-level model expands the
// compressed stream into expected packets; a compare process checks every
// delivered packet, and hand-computed literals pin key results.
module tb_ifmap_decompressor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] comp_data_in;
  logic        comp_valid_in;
  logic        comp_ready_out;
  logic        global_buffer_req;
  logic        decompressor_ack;
  logic [72:0] decompressed_fifo_packet;
  logic        frame_done;

  logic [63:0] pk_data;
  logic [7:0]  pk_mask;
  logic        pk_valid;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  m;
  } pkt_t;

  pkt_t       exp_q[$];
  pkt_t       ack_log[$];
  logic [7:0] pend[$];
  int checks = 0;
  int errors = 0;
  int exp_fd = 0;
  int got_fd = 0;

  ifmap_decompressor #(.FIFO_DEPTH(4), .PACKET_BYTES(8)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .comp_data_in             (comp_data_in),
    .comp_valid_in            (comp_valid_in),
    .comp_ready_out           (comp_ready_out),
    .global_buffer_req        (global_buffer_req),
    .decompressor_ack         (decompressor_ack),
    .decompressed_fifo_packet (decompressed_fifo_packet),
    .frame_done               (frame_done)
  );

  assign pk_data  = decompressed_fifo_packet[63:0];
  assign pk_mask  = decompressed_fifo_packet[71:64];
  assign pk_valid = decompressed_fifo_packet[72];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Model: bytes of the current frame collect in pend; every 8 make a packet.
  function automatic void model_emit();
    pkt_t p;
    p.d = 64'd0;
    p.m = 8'd0;
    for (int i = 0; i < pend.size(); i++) begin
      p.d[8*i +: 8] = pend[i];
      p.m[i]        = 1'b1;
    end
    pend.delete();
    exp_q.push_back(p);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    pend.push_back(b);
    if (pend.size() == 8) model_emit();
  endfunction

  function automatic void model_token(input logic [15:0] t);
    if (!t[15]) begin
      model_byte(t[7:0]);
    end else begin
      for (int k = 0; k < int'(t[7:0]); k++) model_byte(8'h00);
    end
    if (t[14]) begin
      if (pend.size() != 0) model_emit();
      exp_fd++;
    end
  endfunction

  function automatic void model_clear();
    pend.delete();
    exp_q.delete();
  endfunction

  // Compare process: every delivered packet against the model, every cycle.
  always @(negedge clk) begin
    pkt_t e;
    if (rst !== 1'b1) begin
      check("ack_rule", decompressor_ack, global_buffer_req & pk_valid);
      if (frame_done === 1'b1) got_fd++;
      if (decompressor_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet actual=%0h required=none", decompressed_fifo_packet);
        end else begin
          e = exp_q.pop_front();
          check("pkt_data", pk_data, e.d);
          check("pkt_mask", pk_mask, e.m);
          ack_log.push_back({pk_data, pk_mask});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] t);
    bit ok;
    ok = 1'b0;
    comp_data_in  = t;
    comp_valid_in = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (comp_ready_out === 1'b1) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    comp_valid_in = 1'b0;
    if (ok) begin
      model_token(t);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted token=%h", t);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    ack_log.delete();
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_fd(input string name);
    for (int c = 0; c < 300 && got_fd != exp_fd; c++) tick();
    check(name, got_fd, exp_fd);
  endtask

  task automatic idle_drop(input logic [15:0] t);
    comp_data_in  = t;
    comp_valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_ready", comp_ready_out, 1'b0);
      @(posedge clk);
      #1;
    end
    comp_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit found;
    rst               = 1'b1;
    start             = 1'b0;
    comp_data_in      = 16'h0000;
    comp_valid_in     = 1'b0;
    global_buffer_req = 1'b0;
    repeat (3) tick();

    // Reset state while rst is held, then in IDLE after release.
    @(negedge clk);
    check("rst_packet_bus", decompressed_fifo_packet, 73'd0);
    check("rst_ready", comp_ready_out, 1'b0);
    check("rst_ack", decompressor_ack, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("idle_packet_valid", pk_valid, 1'b0);
    @(posedge clk);
    #1;

    // Tokens in IDLE are dropped.
    idle_drop(16'h0055);

    // Eight literals: one full packet, ack two cycles after the last token.
    global_buffer_req = 1'b1;
    do_start();
    for (int i = 1; i <= 8; i++) send({8'h00, 8'(i)});
    lat   = 0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      lat++;
      if (decompressor_ack === 1'b1) found = 1'b1;
    end
    @(posedge clk);
    #1;
    check("t1_ack_latency", lat, 2);
    check("t1_count", ack_log.size(), 1);
    check("t1_packet", ack_log[0], {64'h0807060504030201, 8'hFF});
    check("t1_no_frame_done", got_fd, 0);

    // Three literals then run of 20 with last.
    do_start();
    send(16'h0011);
    send(16'h0022);
    send(16'h0033);
    send(16'hC014);
    wait_fd("t2_frame_done");
    wait_drain("t2_drain");
    check("t2_count", ack_log.size(), 3);
    check("t2_pkt0", ack_log[0], {64'h0000000000332211, 8'hFF});
    check("t2_pkt1", ack_log[1], {64'h0000000000000000, 8'hFF});
    check("t2_pkt2", ack_log[2], {64'h0000000000000000, 8'h7F});
    check("t2_fd_once", got_fd, 1);

    // FIFO full backpressure, then simultaneous pop and push.
    global_buffer_req = 1'b0;
    do_start();
    for (int i = 0; i < 40; i++) send({8'h00, 8'(i + 1)});
    @(negedge clk);
    check("t3_ready_low", comp_ready_out, 1'b0);
    check("t3_fifo_valid", pk_valid, 1'b1);
    @(posedge clk);
    #1;
    global_buffer_req = 1'b1;
    @(negedge clk);
    check("t3_ack", decompressor_ack, 1'b1);
    @(posedge clk);
    #1;
    global_buffer_req = 1'b0;
    @(negedge clk);
    check("t3_ready_back", comp_ready_out, 1'b1);
    check("t3_still_valid", pk_valid, 1'b1);
    @(posedge clk);
    #1;
    global_buffer_req = 1'b1;
    wait_drain("t3_drain");
    check("t3_count", ack_log.size(), 5);
    check("t3_pkt0", ack_log[0], {64'h0807060504030201, 8'hFF});
    check("t3_pkt4", ack_log[4], {64'h2827262524232221, 8'hFF});

    // Start in the middle of a long run restarts a clean frame.
    global_buffer_req = 1'b0;
    do_start();
    send(16'h8064);
    repeat (3) tick();
    do_start();
    @(negedge clk);
    check("t4_packet_valid", pk_valid, 1'b0);
    check("t4_ready", comp_ready_out, 1'b1);
    @(posedge clk);
    #1;
    global_buffer_req = 1'b1;
    for (int i = 0; i < 7; i++) send({8'h00, 8'(8'hA0 + i)});
    send(16'h40A7);
    wait_fd("t4_frame_done");
    wait_drain("t4_drain");
    check("t4_count", ack_log.size(), 1);
    check("t4_pkt0", ack_log[0], {64'hA7A6A5A4A3A2A1A0, 8'hFF});

    // Zero-length run is a no-op; single-byte partial packet.
    do_start();
    send(16'h8000);
    send(16'h40AA);
    wait_fd("t5_frame_done");
    wait_drain("t5_drain");
    check("t5_count", ack_log.size(), 1);
    check("t5_pkt0", ack_log[0], {64'h00000000000000AA, 8'h01});

    idle_drop(16'h0077);

    // Partial packet after a full one: stale staging bytes must read as zero.
    do_start();
    for (int i = 0; i < 9; i++) send({8'h00, 8'(8'h51 + i)});
    send(16'h405A);
    wait_fd("t6_frame_done");
    wait_drain("t6_drain");
    check("t6_count", ack_log.size(), 2);
    check("t6_pkt1", ack_log[1], {64'h0000000000005A59, 8'h03});

    // Reset with two packets queued discards them.
    global_buffer_req = 1'b0;
    do_start();
    for (int i = 0; i < 16; i++) send({8'h00, 8'(8'hB0 + i)});
    repeat (3) tick();
    @(negedge clk);
    check("t7_queued", pk_valid, 1'b1);
    @(posedge clk);
    #1;
    rst               = 1'b1;
    global_buffer_req = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t7_packet_valid", pk_valid, 1'b0);
    check("t7_ack", decompressor_ack, 1'b0);
    check("t7_packet_bus", decompressed_fifo_packet, 73'd0);
    check("t7_ready", comp_ready_out, 1'b0);
    @(posedge clk);
    #1;
    repeat (3) tick();
    check("final_frame_done", got_fd, exp_fd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
